// File: rtl/i2c_arb_pkg.sv
// Shared types, default timing constants and round-robin selection for the I2C bus arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    HOLDOFF = 2'd3
  } arb_state_t;

  localparam int unsigned MAX_MASTER         = 8;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_CNT_W          = 20;
  localparam int unsigned DEF_GRANT_TIMEOUT  = 1000;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 64;
  localparam int unsigned DEF_BUSY_TIMEOUT   = 100000;

  // First eligible index at or after ptr, wrapping modulo n; returns ptr when nothing is eligible.
  function automatic logic [2:0] rr_pick(input logic [MAX_MASTER-1:0] elig,
                                         input logic [2:0]            ptr,
                                         input int unsigned           n);
    logic        found;
    int unsigned j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_MASTER; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if (!found && (k < n) && elig[3'(j)]) begin
        rr_pick = 3'(j);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// Synchronizes SCL/SDA and emits registered START/STOP pulses plus an SCL edge strobe.
module i2c_bus_cond_detect
  import i2c_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic start_seen,
  output logic stop_seen,
  output logic scl_edge
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so presetting to 1 avoids a false condition out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      start_seen <= 1'b0;
      stop_seen  <= 1'b0;
      scl_edge   <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev   <= scl_s;
      sda_prev   <= sda_s;
      start_seen <= scl_prev & scl_s & sda_prev & ~sda_s;
      stop_seen  <= scl_prev & scl_s & ~sda_prev & sda_s;
      scl_edge   <= scl_prev ^ scl_s;
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner selection for a shared I2C bus, holding grant across START..STOP.
// Optional BUSY-state SCL watchdog enabled by defining I2C_ARB_WATCHDOG_EN.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_MASTER       = 4,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned GRANT_TIMEOUT  = DEF_GRANT_TIMEOUT,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned BUSY_TIMEOUT   = DEF_BUSY_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTER-1:0]         req,
  input  logic [N_MASTER-1:0]         master_mask,
  input  logic                        scl_i,
  input  logic                        sda_i,
  input  logic                        err_clear,
  output logic [N_MASTER-1:0]         grant,
  output logic                        grant_valid,
  output logic [$clog2(N_MASTER)-1:0] grant_id,
  output logic                        bus_busy,
  output logic                        start_seen,
  output logic                        stop_seen,
  output logic                        timeout_err
);

  localparam int unsigned ID_W = $clog2(N_MASTER);
  localparam logic [CNT_W-1:0] GRANT_LIM   = CNT_W'(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLDOFF_LIM = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] BUSY_LIM    = CNT_W'(BUSY_TIMEOUT);

  arb_state_t            state;
  logic [ID_W-1:0]       ptr;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  scl_edge;
  logic [N_MASTER-1:0]   eligible;
  logic [MAX_MASTER-1:0] elig_ext;
  logic [2:0]            pick;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       ptr_after;
  logic [N_MASTER-1:0]   sel_onehot;

  i2c_bus_cond_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond_detect (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .start_seen(start_seen),
    .stop_seen (stop_seen),
    .scl_edge  (scl_edge)
  );

  // Selection and saturating counter increment.
  always_comb begin
    eligible   = req & master_mask;
    elig_ext   = MAX_MASTER'(eligible);
    pick       = rr_pick(elig_ext, 3'(ptr), N_MASTER);
    sel_id     = ID_W'(pick);
    ptr_after  = (sel_id == ID_W'(N_MASTER - 1)) ? '0 : sel_id + ID_W'(1);
    sel_onehot = {{(N_MASTER-1){1'b0}}, 1'b1} << sel_id;
    cnt_nxt    = (&cnt) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Later assignments in the case below let a new error win over err_clear.
      if (err_clear) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            grant       <= sel_onehot;
            grant_valid <= 1'b1;
            grant_id    <= sel_id;
            ptr         <= ptr_after;
            cnt         <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (start_seen) begin
            bus_busy <= 1'b1;
            cnt      <= '0;
            state    <= BUSY;
          end else if (!req[grant_id] || !master_mask[grant_id]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (cnt_nxt >= GRANT_LIM) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            grant_valid <= 1'b0;
            cnt         <= '0;
            state       <= HOLDOFF;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        BUSY: begin
          // Requests are ignored here; only STOP or a mask revoke end ownership.
          if (stop_seen || !master_mask[grant_id]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            bus_busy    <= 1'b0;
            cnt         <= '0;
            state       <= HOLDOFF;
          end else if (scl_edge) begin
            cnt <= '0;
          end else if (cnt_nxt >= BUSY_LIM) begin
`ifdef I2C_ARB_WATCHDOG_EN
            timeout_err <= 1'b1;
            grant       <= '0;
            grant_valid <= 1'b0;
            bus_busy    <= 1'b0;
            cnt         <= '0;
            state       <= HOLDOFF;
`else
            cnt <= BUSY_LIM;
`endif
          end else begin
            cnt <= cnt_nxt;
          end
        end
        HOLDOFF: begin
          if (start_seen) begin
            cnt <= '0;
          end else if (cnt_nxt >= HOLDOFF_LIM) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter; define I2C_ARB_WATCHDOG_EN to cover the watchdog build.
module tb_i2c_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] master_mask;
  logic       scl_i;
  logic       sda_i;
  logic       err_clear;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       start_seen;
  logic       stop_seen;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  i2c_bus_arbiter #(
    .N_MASTER      (4),
    .SYNC_STAGES   (2),
    .CNT_W         (20),
    .GRANT_TIMEOUT (8),
    .HOLDOFF_CYCLES(4),
    .BUSY_TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .master_mask(master_mask),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .err_clear  (err_clear),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .bus_busy   (bus_busy),
    .start_seen (start_seen),
    .stop_seen  (stop_seen),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; master_mask = 4'b1111;
    scl_i = 1'b1; sda_i = 1'b1; err_clear = 1'b0;
    tick(2);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_valid", 32'(grant_valid), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_bus_busy", 32'(bus_busy), 32'h0);
    check("rst_pulses", 32'({start_seen, stop_seen}), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    rst = 1'b0;
    tick(1);
    check("idle_no_req", 32'(grant), 32'h0);

    // Single request, full START/STOP transaction and holdoff.
    req = 4'b0010;
    tick(1);
    check("single_grant", 32'(grant), 32'h2);
    check("single_grant_valid", 32'(grant_valid), 32'h1);
    check("single_grant_id", 32'(grant_id), 32'h1);
    sda_i = 1'b0;
    tick(3);
    check("single_start_pulse", 32'(start_seen), 32'h1);
    tick(1);
    check("single_busy", 32'(bus_busy), 32'h1);
    check("single_start_one_cycle", 32'(start_seen), 32'h0);
    sda_i = 1'b1;
    tick(3);
    check("single_stop_pulse", 32'(stop_seen), 32'h1);
    check("single_grant_until_stop", 32'(grant), 32'h2);
    tick(1);
    check("single_release", 32'(grant), 32'h0);
    check("single_busy_low", 32'(bus_busy), 32'h0);
    check("single_last_owner", 32'(grant_id), 32'h1);
    tick(4);
    check("holdoff_end_no_grant", 32'(grant), 32'h0);
    tick(1);
    check("holdoff_regrant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick(1);
    check("req_drop_release", 32'(grant), 32'h0);
    check("req_drop_no_err", 32'(timeout_err), 32'h0);

    // Round robin with all four requesting, from a fresh pointer.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    tick(1);
    check("rr_grant_0", 32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      sda_i = 1'b0;
      tick(4);
      sda_i = 1'b1;
      tick(4);
      tick(5);
      check("rr_grant_next", 32'(grant), 32'(rr_exp[i]));
    end
    req = 4'b0000;
    tick(1);

    // Grant timeout with no START, then err_clear.
    req = 4'b0100;
    tick(1);
    check("to_grant", 32'(grant), 32'h4);
    tick(7);
    check("to_still_granted", 32'(grant), 32'h4);
    check("to_no_err_yet", 32'(timeout_err), 32'h0);
    tick(1);
    check("to_err_set", 32'(timeout_err), 32'h1);
    check("to_grant_cleared", 32'(grant), 32'h0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("to_err_cleared", 32'(timeout_err), 32'h0);
    req = 4'b0000;
    tick(6);

    // Mask filtering and forced revoke during BUSY.
    req = 4'b0011; master_mask = 4'b0010;
    tick(1);
    check("mask_grant", 32'(grant), 32'h2);
    sda_i = 1'b0;
    tick(4);
    check("mask_busy", 32'(bus_busy), 32'h1);
    master_mask = 4'b0000;
    tick(1);
    check("mask_revoke_grant", 32'(grant), 32'h0);
    check("mask_revoke_no_err", 32'(timeout_err), 32'h0);
    check("mask_revoke_not_busy", 32'(bus_busy), 32'h0);
    sda_i = 1'b1; req = 4'b0000; master_mask = 4'b1111;
    tick(8);

    // Repeated START while master 2 owns the bus; req drop ignored in BUSY.
    req = 4'b0100;
    tick(1);
    check("rs_grant", 32'(grant), 32'h4);
    sda_i = 1'b0;
    tick(3);
    check("rs_start1", 32'(start_seen), 32'h1);
    tick(1);
    scl_i = 1'b0;
    tick(2);
    sda_i = 1'b1;
    tick(2);
    scl_i = 1'b1;
    tick(2);
    check("rs_no_stop_while_scl_low", 32'(stop_seen), 32'h0);
    sda_i = 1'b0;
    tick(3);
    check("rs_start2", 32'(start_seen), 32'h1);
    tick(1);
    check("rs_grant_held", 32'(grant), 32'h4);
    check("rs_busy_held", 32'(bus_busy), 32'h1);
    req = 4'b0000;
    tick(2);
    check("rs_req_drop_ignored", 32'(grant), 32'h4);
    sda_i = 1'b1;
    tick(4);
    check("rs_release_on_stop", 32'(grant), 32'h0);
    tick(6);

    // SCL frozen in BUSY.
    req = 4'b0001;
    tick(1);
    check("wd_grant", 32'(grant), 32'h1);
    sda_i = 1'b0;
    tick(4);
    check("wd_busy", 32'(bus_busy), 32'h1);
`ifdef I2C_ARB_WATCHDOG_EN
    tick(15);
    check("wd_before_limit", 32'(grant), 32'h1);
    check("wd_no_err_yet", 32'(timeout_err), 32'h0);
    tick(1);
    check("wd_err", 32'(timeout_err), 32'h1);
    check("wd_grant_cleared", 32'(grant), 32'h0);
    check("wd_busy_cleared", 32'(bus_busy), 32'h0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
`else
    tick(20);
    check("nowd_grant_held", 32'(grant), 32'h1);
    check("nowd_busy_held", 32'(bus_busy), 32'h1);
    check("nowd_no_err", 32'(timeout_err), 32'h0);
`endif
    sda_i = 1'b1;
    tick(4);
    req = 4'b0000;
    tick(6);

    // Reset in the middle of a transaction.
    req = 4'b0010;
    tick(1);
    check("rm_grant", 32'(grant), 32'h2);
    sda_i = 1'b0;
    tick(4);
    check("rm_busy", 32'(bus_busy), 32'h1);
    rst = 1'b1;
    tick(1);
    check("rm_grant_dropped", 32'(grant), 32'h0);
    check("rm_valid_dropped", 32'(grant_valid), 32'h0);
    check("rm_busy_dropped", 32'(bus_busy), 32'h0);
    check("rm_id_reset", 32'(grant_id), 32'h0);
    rst = 1'b0; req = 4'b0000; sda_i = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
